// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller uses the master modport; the datapath (or a bench) uses slave.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic       bus_fault;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, bus_fault
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, bus_fault
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (lw/sw/R-type/beq/addi/j) for a shared-ALU, unified-memory datapath.
// Memory states stretch on mem_ready and give up with a bus_fault pulse after TIMEOUT_CYCLES waits.
module mips_multicycle_ctrl #(
  parameter bit          USE_MEM_READY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  mips_multicycle_ctrl_if.master       bus
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic       ready_c;
  logic       timeout_c;
  logic       mem_req_c, iord_c, memwrite_c, irwrite_c, pcwrite_c, branch_c;
  logic       regwrite_c, regdst_c, memtoreg_c, alusrca_c, illegal_c, fault_c;
  logic [1:0] alusrcb_c, pcsrc_c;
  logic [2:0] alucontrol_c;

  function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return ALU_ADD;
    endcase
  endfunction

  assign ready_c = USE_MEM_READY ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    iord_c       = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    pcwrite_c    = 1'b0;
    branch_c     = 1'b0;
    regwrite_c   = 1'b0;
    regdst_c     = 1'b0;
    memtoreg_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    alucontrol_c = ALU_ADD;
    illegal_c    = 1'b0;
    fault_c      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = ready_c;
        pcwrite_c = ready_c;
        if (ready_c) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (ready_c) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        iord_c     = 1'b1;
        memwrite_c = ready_c;
        if (ready_c) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = alu_from_funct(bus.funct);
        state_d      = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        branch_c     = 1'b1;
        pcsrc_c      = 2'b01;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = 2'b10;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A late mem_ready on the last allowed wait cycle still completes the access.
    timeout_c = (TIMEOUT_CYCLES != 0) && mem_req_c && !ready_c && (wait_q == CNT_W'(TO_LAST));
    if (timeout_c) begin
      fault_c = 1'b1;
      state_d = S_FETCH;
    end

    if (timeout_c || (state_d != state_q)) wait_d = '0;
    else if (mem_req_c && !ready_c)        wait_d = wait_q + 1'b1;
    else                                   wait_d = '0;
  end

  assign bus.mem_req    = reset & mem_req_c;
  assign bus.iord       = reset & iord_c;
  assign bus.memwrite   = reset & memwrite_c;
  assign bus.irwrite    = reset & irwrite_c;
  assign bus.pcen       = reset & (pcwrite_c | (branch_c & bus.zero));
  assign bus.regwrite   = reset & regwrite_c;
  assign bus.regdst     = reset & regdst_c;
  assign bus.memtoreg   = reset & memtoreg_c;
  assign bus.alusrca    = reset & alusrca_c;
  assign bus.alusrcb    = reset ? alusrcb_c : 2'b00;
  assign bus.pcsrc      = reset ? pcsrc_c : 2'b00;
  assign bus.alucontrol = reset ? alucontrol_c : 3'b000;
  assign bus.illegal_op = reset & illegal_c;
  assign bus.bus_fault  = reset & fault_c;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-instruction reference traces built from
// the instruction semantics are queued by the stimulus and compared cycle by cycle by a monitor.
module tb_mips_multicycle_ctrl;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic       mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op, bus_fault;
  } ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.USE_MEM_READY(1'b1), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ctl_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic ctl_t sample();
    ctl_t c;
    c = '{bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite, bus.regdst,
          bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal_op,
          bus.bus_fault};
    return c;
  endfunction

  // Monitor: every cycle that has a queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %b exp %b", t, a, e);
      end
    end
  end

  // ---------- reference model: expected controls per instruction phase ----------
  function automatic ctl_t idle();
    ctl_t c = '0;
    c.alucontrol = 3'b010;
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic ctl_t e_fetch(input bit rdy);
    ctl_t c = idle();
    c.mem_req = 1'b1;
    c.alusrcb = 2'b01;
    c.irwrite = rdy;
    c.pcen    = rdy;
    return c;
  endfunction

  function automatic ctl_t e_decode(input logic [5:0] o);
    ctl_t c = idle();
    c.alusrcb    = 2'b11;
    c.illegal_op = !is_legal(o);
    return c;
  endfunction

  function automatic ctl_t e_addr_calc();
    ctl_t c = idle();
    c.alusrca = 1'b1;
    c.alusrcb = 2'b10;
    return c;
  endfunction

  function automatic ctl_t e_data_mem(input bit store, input bit rdy);
    ctl_t c = idle();
    c.mem_req  = 1'b1;
    c.iord     = 1'b1;
    c.memwrite = store & rdy;
    return c;
  endfunction

  function automatic ctl_t e_writeback(input bit from_mem, input bit to_rd);
    ctl_t c = idle();
    c.regwrite = 1'b1;
    c.memtoreg = from_mem;
    c.regdst   = to_rd;
    return c;
  endfunction

  // ---------- stimulus ----------
  task automatic cyc(input logic [5:0] o, input logic [5:0] f, input bit rdy, input bit z,
                     input ctl_t e, input string t);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.op        = o;
    bus.funct     = f;
    bus.mem_ready = rdy;
    bus.zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic reset_cyc(input string t);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.mem_ready = 1'($urandom);
    bus.zero      = 1'($urandom);
    exp_q.push_back('0);
    tag_q.push_back(t);
  endtask

  // Memory phase with a given number of not-ready cycles; ok=0 when it times out.
  task automatic mem_phase(input int waits, input bit is_fetch, input bit store,
                           input logic [5:0] o, input logic [5:0] f, input string t,
                           output bit ok);
    ctl_t e;
    ok = 1'b1;
    for (int i = 0; i < waits; i++) begin
      e = is_fetch ? e_fetch(1'b0) : e_data_mem(store, 1'b0);
      if (i == int'(TO) - 1) begin
        e.bus_fault = 1'b1;
        cyc(o, f, 1'b0, 1'($urandom), e, {t, "_timeout"});
        ok = 1'b0;
        return;
      end
      cyc(o, f, 1'b0, 1'($urandom), e, {t, "_wait"});
    end
    e = is_fetch ? e_fetch(1'b1) : e_data_mem(store, 1'b1);
    cyc(o, f, 1'b1, 1'($urandom), e, t);
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int fwait,
                          input int mwait, input bit z);
    bit   ok;
    ctl_t e;
    mem_phase(fwait, 1'b1, 1'b0, 6'($urandom), 6'($urandom), "fetch", ok);
    if (!ok) return;
    cyc(o, f, 1'($urandom), 1'($urandom), e_decode(o), "decode");
    if (!is_legal(o)) return;
    case (o)
      6'b100011, 6'b101011: begin
        cyc(o, f, 1'($urandom), 1'($urandom), e_addr_calc(), "memadr");
        mem_phase(mwait, 1'b0, o == 6'b101011, o, f, (o == 6'b101011) ? "memwr" : "memrd", ok);
        if (ok && o == 6'b100011)
          cyc(o, f, 1'($urandom), 1'($urandom), e_writeback(1'b1, 1'b0), "memwb");
      end
      6'b000000: begin
        e = idle();
        e.alusrca    = 1'b1;
        e.alucontrol = alu_ref(f);
        cyc(o, f, 1'($urandom), 1'($urandom), e, "rtype_ex");
        cyc(o, f, 1'($urandom), 1'($urandom), e_writeback(1'b0, 1'b1), "rtype_wb");
      end
      6'b000100: begin
        e = idle();
        e.alusrca    = 1'b1;
        e.alucontrol = 3'b110;
        e.pcsrc      = 2'b01;
        e.pcen       = z;
        cyc(o, f, 1'($urandom), z, e, z ? "beq_taken" : "beq_not_taken");
      end
      6'b001000: begin
        cyc(o, f, 1'($urandom), 1'($urandom), e_addr_calc(), "addi_ex");
        cyc(o, f, 1'($urandom), 1'($urandom), e_writeback(1'b0, 1'b0), "addi_wb");
      end
      default: begin
        e = idle();
        e.pcen  = 1'b1;
        e.pcsrc = 2'b10;
        cyc(o, f, 1'($urandom), 1'($urandom), e, "jump");
      end
    endcase
  endtask

  initial begin
    bit          ok;
    logic [5:0]  o, f;
    logic [5:0]  fset [6];
    fset = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    rst = 1'b0; bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) reset_cyc("reset");

    // Directed cases first.
    do_instr(6'b100011, 6'b000000, 0, 0, 1'b0);   // lw
    do_instr(6'b100011, 6'b000000, 0, 2, 1'b0);   // lw, 2 wait cycles
    do_instr(6'b000000, 6'b101010, 0, 0, 1'b0);   // slt
    do_instr(6'b000000, 6'b000000, 0, 0, 1'b0);   // unknown funct -> add
    do_instr(6'b000100, 6'b000000, 0, 0, 1'b1);   // beq taken
    do_instr(6'b000100, 6'b000000, 0, 0, 1'b0);   // beq not taken
    do_instr(6'b111111, 6'b000000, 0, 0, 1'b0);   // illegal
    do_instr(6'b101011, 6'b000000, 0, 9, 1'b0);   // sw timeout
    do_instr(6'b101011, 6'b000000, 0, 3, 1'b0);   // sw, ready on the last allowed cycle
    do_instr(6'b001000, 6'b000000, 5, 0, 1'b0);   // fetch timeout
    do_instr(6'b000010, 6'b000000, 0, 0, 1'b0);   // j

    // Reset in the middle of a stalled store.
    cyc(6'($urandom), 6'($urandom), 1'b1, 1'b0, e_fetch(1'b1), "fetch");
    cyc(6'b101011, 6'd0, 1'b0, 1'b0, e_decode(6'b101011), "decode");
    cyc(6'b101011, 6'd0, 1'b0, 1'b0, e_addr_calc(), "memadr");
    cyc(6'b101011, 6'd0, 1'b0, 1'b0, e_data_mem(1'b1, 1'b0), "memwr_wait");
    repeat (2) reset_cyc("reset_mid_memwr");
    do_instr(6'b001000, 6'd0, 0, 0, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2, 3: o = 6'b000000;
        4: o = 6'b000100;
        5: o = 6'b001000;
        6: o = 6'b000010;
        default: begin
          o = 6'($urandom);
          while (is_legal(o)) o = 6'($urandom);
        end
      endcase
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fset[$urandom_range(0, 5)];
      do_instr(o, f, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0,
               $urandom_range(0, 5), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
